// File: rtl/hoplite_rt_pkg.sv
// hoplite_rt_pkg: shared flit routing types, widths and the dimension-ordered route decision
package hoplite_rt_pkg;
  localparam int CNT_W = 16;
  localparam int COORD_W = 16;
  typedef enum logic [1:0] {P_E, P_S, P_EJ} port_e;
  function automatic port_e route(input logic [COORD_W-1:0] dx, dy, mx, my);
    return dx != mx ? P_E : dy != my ? P_S : P_EJ;
  endfunction
endpackage

// File: rtl/hoplite_rt_if.sv
// hoplite_rt_if: router link, PE inject/eject and deflection-count bundle
interface hoplite_rt_if import hoplite_rt_pkg::*; #(parameter int F_W = 36);
  logic w_valid, n_valid, pe_valid, pe_ready, e_valid, s_valid, ej_valid;
  logic [F_W-1:0] w_data, n_data, pe_data, e_data, s_data, ej_data;
  logic [CNT_W-1:0] defl_cnt;
  modport master(output w_valid, w_data, n_valid, n_data, pe_valid, pe_data,
                 input pe_ready, e_valid, e_data, s_valid, s_data, ej_valid, ej_data, defl_cnt);
  modport slave(input w_valid, w_data, n_valid, n_data, pe_valid, pe_data,
                output pe_ready, e_valid, e_data, s_valid, s_data, ej_valid, ej_data, defl_cnt);
endinterface

// File: rtl/hoplite_rt_regulator.sv
// hoplite_rt_regulator: token bucket refilled once per PERIOD cycles, depth BURST
module hoplite_rt_regulator #(
  parameter int PERIOD = 16,
  parameter int BURST = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic consume,
  output logic has_token
);
  localparam int C_W = PERIOD > 1 ? $clog2(PERIOD) : 1;
  localparam int T_W = $clog2(BURST + 1);
  logic [C_W-1:0] cnt;
  logic [T_W-1:0] tok;
  logic wrap, up, dn;
  always_comb begin
    wrap = PERIOD != 0 && cnt == C_W'(PERIOD - 1);
    up = wrap && !consume && tok != T_W'(BURST);
    dn = PERIOD != 0 && consume && !wrap;
    has_token = PERIOD == 0 || tok != '0;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt <= '0;
      tok <= T_W'(BURST);
    end else begin
      cnt <= (wrap || PERIOD == 0) ? '0 : cnt + 1'b1;
      tok <= up ? tok + 1'b1 : dn ? tok - 1'b1 : tok;
    end
  end
endmodule

// File: rtl/hoplite_rt_router.sv
// hoplite_rt_router: registered Hoplite-RT torus router with N-priority deflection and regulated injection
module hoplite_rt_router import hoplite_rt_pkg::*; #(
  parameter int P_W = 32,
  parameter int X_W = 2,
  parameter int Y_W = 2,
  parameter int MY_X = 0,
  parameter int MY_Y = 0,
  parameter int PERIOD = 16,
  parameter int BURST = 4
) (
  input logic clk,
  input logic rst,
  hoplite_rt_if.slave bus
);
  localparam int F_W = P_W + X_W + Y_W;
  function automatic port_e dec(input logic [F_W-1:0] f);
    return route(COORD_W'(f[F_W-1 -: X_W]), COORD_W'(f[P_W +: Y_W]), COORD_W'(MY_X), COORD_W'(MY_Y));
  endfunction
  port_e np, wp, pp;
  logic s_n, ej_n, w_defl, w_e, w_s, w_ej, free, go, e_p, s_p, ej_p, has_token;
  logic e_v, s_v, ej_v;
  logic [F_W-1:0] e_d, s_d, ej_d;
  logic [CNT_W-1:0] defl;
  always_comb begin
    np = dec(bus.n_data);
    wp = dec(bus.w_data);
    pp = dec(bus.pe_data);
    s_n = bus.n_valid && np == P_S;
    ej_n = bus.n_valid && np == P_EJ;
    w_defl = bus.w_valid && (wp == P_S ? s_n : wp == P_EJ ? ej_n : 1'b0);
    w_e = bus.w_valid && (wp == P_E || w_defl);
    w_s = bus.w_valid && wp == P_S && !s_n;
    w_ej = bus.w_valid && wp == P_EJ && !ej_n;
    free = pp == P_E ? !w_e : pp == P_S ? !(s_n || w_s) : !(ej_n || w_ej);
    go = bus.pe_valid && free && has_token;
    e_p = go && pp == P_E;
    s_p = go && pp == P_S;
    ej_p = go && pp == P_EJ;
  end
  hoplite_rt_regulator #(.PERIOD(PERIOD), .BURST(BURST)) u_reg (
    .clk(clk),
    .rst(rst),
    .consume(go),
    .has_token(has_token)
  );
  always_ff @(posedge clk) begin
    if (rst) begin
      e_v <= 1'b0;
      s_v <= 1'b0;
      ej_v <= 1'b0;
      e_d <= '0;
      s_d <= '0;
      ej_d <= '0;
      defl <= '0;
    end else begin
      e_v <= w_e || e_p;
      s_v <= s_n || w_s || s_p;
      ej_v <= ej_n || w_ej || ej_p;
      if (w_e || e_p) e_d <= w_e ? bus.w_data : bus.pe_data;
      if (s_n || w_s || s_p) s_d <= s_n ? bus.n_data : w_s ? bus.w_data : bus.pe_data;
      if (ej_n || w_ej || ej_p) ej_d <= ej_n ? bus.n_data : w_ej ? bus.w_data : bus.pe_data;
      if (w_defl && defl != '1) defl <= defl + 1'b1;
    end
  end
  assign bus.pe_ready = go;
  assign bus.e_valid = e_v;
  assign bus.e_data = e_d;
  assign bus.s_valid = s_v;
  assign bus.s_data = s_d;
  assign bus.ej_valid = ej_v;
  assign bus.ej_data = ej_d;
  assign bus.defl_cnt = defl;
endmodule

// File: tb/tb_hoplite_rt_router.sv
// tb_hoplite_rt_router: directed checks of routing, deflection, regulation, reset and saturation
module tb_hoplite_rt_router;
  logic clk = 0, rst;
  int tests = 0, fails = 0, acc = 0;
  logic [17:0] pv = 18'b111_000_111111111111;
  logic [17:0] rx = 18'b011_000_000100010011;
  always #5 clk = ~clk;
  hoplite_rt_if #(.F_W(36)) ia ();
  hoplite_rt_if #(.F_W(36)) ib ();
  hoplite_rt_router #(.P_W(32), .X_W(2), .Y_W(2), .MY_X(1), .MY_Y(1), .PERIOD(4), .BURST(2))
    dut_a (.clk(clk), .rst(rst), .bus(ia));
  hoplite_rt_router #(.P_W(32), .X_W(2), .Y_W(2), .MY_X(1), .MY_Y(1), .PERIOD(0), .BURST(4))
    dut_b (.clk(clk), .rst(rst), .bus(ib));
  function automatic logic [35:0] mk(input logic [1:0] x, y, input logic [31:0] p);
    return {x, y, p};
  endfunction
  task automatic chk(input string tag, input logic [63:0] obs, exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  always @(negedge clk) begin
    if (ia.n_valid && ia.n_data[35:34] != 2'd1) begin
      fails++;
      $error("FAIL n_illegal_a observed=%h expected dst_x=1", ia.n_data);
    end
    if (ib.n_valid && ib.n_data[35:34] != 2'd1) begin
      fails++;
      $error("FAIL n_illegal_b observed=%h expected dst_x=1", ib.n_data);
    end
  end
  initial begin
    rst = 1;
    {ia.w_valid, ia.n_valid, ia.pe_valid, ib.w_valid, ib.n_valid, ib.pe_valid} = '0;
    {ia.w_data, ia.n_data, ia.pe_data, ib.w_data, ib.n_data, ib.pe_data} = '0;
    repeat (2) tick();
    chk("rst_valids", {ia.e_valid, ia.s_valid, ia.ej_valid}, 0);
    chk("rst_data", {ia.e_data ^ ia.s_data, ia.ej_data}, 0);
    chk("rst_defl", ia.defl_cnt, 0);
    rst = 0;
    ia.n_valid = 1; ia.n_data = mk(1, 2, 32'hA1);
    ia.w_valid = 1; ia.w_data = mk(3, 0, 32'hB1);
    tick();
    chk("t1_s", {ia.s_valid, ia.s_data}, {1'b1, mk(1, 2, 32'hA1)});
    chk("t1_e", {ia.e_valid, ia.e_data}, {1'b1, mk(3, 0, 32'hB1)});
    chk("t1_ej_v", ia.ej_valid, 0);
    chk("t1_defl", ia.defl_cnt, 0);
    ia.n_data = mk(1, 2, 32'hA2); ia.w_data = mk(1, 3, 32'hB2);
    tick();
    chk("t2_s", {ia.s_valid, ia.s_data}, {1'b1, mk(1, 2, 32'hA2)});
    chk("t2_e", {ia.e_valid, ia.e_data}, {1'b1, mk(1, 3, 32'hB2)});
    chk("t2_defl", ia.defl_cnt, 1);
    ia.n_valid = 0; ia.w_data = mk(1, 1, 32'hB3);
    tick();
    chk("t3_ej", {ia.ej_valid, ia.ej_data}, {1'b1, mk(1, 1, 32'hB3)});
    chk("t3_e_hold", {ia.e_valid, ia.e_data}, {1'b0, mk(1, 3, 32'hB2)});
    chk("t3_s_v", ia.s_valid, 0);
    ia.n_valid = 1; ia.n_data = mk(1, 1, 32'hA4); ia.w_data = mk(1, 1, 32'hB4);
    ia.pe_valid = 1; ia.pe_data = mk(2, 0, 32'hC4);
    #1 chk("t4_pe_ready", ia.pe_ready, 0);
    tick();
    chk("t4_ej", {ia.ej_valid, ia.ej_data}, {1'b1, mk(1, 1, 32'hA4)});
    chk("t4_e", {ia.e_valid, ia.e_data}, {1'b1, mk(1, 1, 32'hB4)});
    chk("t4_defl", ia.defl_cnt, 2);
    ia.n_valid = 0; ia.w_data = mk(3, 0, 32'hB5); ia.pe_data = mk(1, 0, 32'hC5);
    #1 chk("t5_pe_ready", ia.pe_ready, 1);
    tick();
    chk("t5_s", {ia.s_valid, ia.s_data}, {1'b1, mk(1, 0, 32'hC5)});
    chk("t5_e", {ia.e_valid, ia.e_data}, {1'b1, mk(3, 0, 32'hB5)});
    ia.w_data = mk(1, 0, 32'hB6); ia.pe_data = mk(1, 0, 32'hC6);
    #1 chk("t6_pe_ready", ia.pe_ready, 0);
    tick();
    chk("t6_s", {ia.s_valid, ia.s_data}, {1'b1, mk(1, 0, 32'hB6)});
    chk("t6_e_v", ia.e_valid, 0);
    ia.n_valid = 1; ia.n_data = mk(1, 2, 32'hA7);
    ia.w_data = mk(3, 0, 32'hB7); ia.pe_data = mk(1, 1, 32'hC7);
    #1 chk("t7_pe_ready", ia.pe_ready, 1);
    tick();
    chk("t7_all_v", {ia.e_valid, ia.s_valid, ia.ej_valid}, 3'b111);
    rst = 1;
    tick();
    chk("mrst_valids", {ia.e_valid, ia.s_valid, ia.ej_valid}, 0);
    chk("mrst_defl", ia.defl_cnt, 0);
    #1 chk("mrst_pe_ready", ia.pe_ready, 1);
    rst = 0; ia.n_valid = 0; ia.w_valid = 0;
    for (int k = 1; k <= 18; k++) begin
      ia.pe_valid = pv[k-1];
      ia.pe_data = mk(1, 1, k);
      #1 chk($sformatf("tok_k%0d", k), ia.pe_ready, rx[k-1]);
      tick();
      if (k == 1) chk("tok_ej_first", {ia.ej_valid, ia.ej_data}, {1'b1, mk(1, 1, 1)});
    end
    ia.pe_valid = 0;
    ib.pe_valid = 1; ib.pe_data = mk(1, 1, 32'hD0);
    for (int i = 0; i < 100; i++) begin
      #1 if (ib.pe_ready) acc++;
      tick();
    end
    chk("p0_accepts", acc, 100);
    chk("p0_ej_v", ib.ej_valid, 1);
    ib.pe_valid = 0;
    ib.n_valid = 1; ib.n_data = mk(1, 1, 32'hA9);
    ib.w_valid = 1; ib.w_data = mk(1, 1, 32'hB9);
    chk("sat_start", ib.defl_cnt, 0);
    repeat (65534) tick();
    chk("sat_fffe", ib.defl_cnt, 16'hFFFE);
    repeat (4466) tick();
    chk("sat_ffff", ib.defl_cnt, 16'hFFFF);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
